// File: rtl/operand_issue_if.sv
// Decode, issue-output and writeback signals of the operand issue stage.
// The bench drives the master side; operand_issue uses the slave side.
interface operand_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sr1;
    logic [2:0]  in_sr2;
    logic        in_sr1_use;
    logic        in_sr2_use;
    logic [2:0]  in_dr;
    logic        in_dr_write;
    logic        in_cc_use;
    logic        in_cc_write;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sr1_data;
    logic [15:0] out_sr2_data;
    logic [2:0]  out_cc;
    logic        wb_valid;
    logic        wb_write;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic        wb_load_cc;
    logic [2:0]  wb_cc;
    logic        sb_error;

    modport master (
        output in_valid, in_sr1, in_sr2, in_sr1_use, in_sr2_use,
               in_dr, in_dr_write, in_cc_use, in_cc_write,
               out_ready, wb_valid, wb_write, wb_dr, wb_data, wb_load_cc, wb_cc,
        input  in_ready, out_valid, out_sr1_data, out_sr2_data, out_cc, sb_error
    );

    modport slave (
        input  in_valid, in_sr1, in_sr2, in_sr1_use, in_sr2_use,
               in_dr, in_dr_write, in_cc_use, in_cc_write,
               out_ready, wb_valid, wb_write, wb_dr, wb_data, wb_load_cc, wb_cc,
        output in_ready, out_valid, out_sr1_data, out_sr2_data, out_cc, sb_error
    );
endinterface

// File: rtl/operand_issue.sv
// Operand issue stage: register file + NZP with writeback bypass, per-register
// pending-write scoreboard and a one-entry output register.
module operand_issue (
    input logic     clk,
    input logic     reset_n,
    operand_issue_if.slave bus
);
    logic [15:0] rf [8];
    logic [2:0]  nzp;
    logic [1:0]  pend [8];
    logic [1:0]  cc_pend;
    logic        out_valid_q;
    logic [15:0] d1_q, d2_q;
    logic [2:0]  cc_q;
    logic        err_q;

    logic        wb_reg, wb_ccld;
    logic [15:0] sr1_val, sr2_val;
    logic [2:0]  cc_val;
    logic        sr1_ok, sr2_ok, cc_ok, hazard, ready, issue;
    logic [7:0]  p_inc, p_dec;

    always_comb begin
        wb_reg  = bus.wb_valid && bus.wb_write;
        wb_ccld = bus.wb_valid && bus.wb_load_cc;

        sr1_val = (wb_reg && bus.wb_dr == bus.in_sr1) ? bus.wb_data : rf[bus.in_sr1];
        sr2_val = (wb_reg && bus.wb_dr == bus.in_sr2) ? bus.wb_data : rf[bus.in_sr2];
        cc_val  = wb_ccld ? bus.wb_cc : nzp;

        // A source with exactly one outstanding write is ready when that write lands now.
        sr1_ok = !bus.in_sr1_use || pend[bus.in_sr1] == 2'd0 ||
                 (pend[bus.in_sr1] == 2'd1 && wb_reg && bus.wb_dr == bus.in_sr1);
        sr2_ok = !bus.in_sr2_use || pend[bus.in_sr2] == 2'd0 ||
                 (pend[bus.in_sr2] == 2'd1 && wb_reg && bus.wb_dr == bus.in_sr2);
        cc_ok  = !bus.in_cc_use || cc_pend == 2'd0 || (cc_pend == 2'd1 && wb_ccld);

        hazard = !sr1_ok || !sr2_ok || !cc_ok ||
                 (bus.in_dr_write && pend[bus.in_dr] == 2'd3) ||
                 (bus.in_cc_write && cc_pend == 2'd3);
        ready  = !hazard && (!out_valid_q || bus.out_ready);
        issue  = bus.in_valid && ready;

        p_inc = '0;
        p_dec = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            p_inc[i] = issue && bus.in_dr_write && bus.in_dr == 3'(i);
            p_dec[i] = wb_reg && bus.wb_dr == 3'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                rf[i]   <= '0;
                pend[i] <= '0;
            end
            nzp         <= 3'b010;
            cc_pend     <= '0;
            out_valid_q <= 1'b0;
            d1_q        <= '0;
            d2_q        <= '0;
            cc_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            if (wb_reg)
                rf[bus.wb_dr] <= bus.wb_data;
            if (wb_ccld)
                nzp <= bus.wb_cc;

            // Underflow keeps the counter at zero but the writeback itself still lands.
            for (int unsigned i = 0; i < 8; i++) begin
                if (p_inc[i] && !p_dec[i])
                    pend[i] <= pend[i] + 2'd1;
                else if (!p_inc[i] && p_dec[i]) begin
                    if (pend[i] == 2'd0)
                        err_q <= 1'b1;
                    else
                        pend[i] <= pend[i] - 2'd1;
                end
            end

            if ((issue && bus.in_cc_write) && !wb_ccld)
                cc_pend <= cc_pend + 2'd1;
            else if (!(issue && bus.in_cc_write) && wb_ccld) begin
                if (cc_pend == 2'd0)
                    err_q <= 1'b1;
                else
                    cc_pend <= cc_pend - 2'd1;
            end

            if (issue) begin
                out_valid_q <= 1'b1;
                d1_q        <= sr1_val;
                d2_q        <= sr2_val;
                cc_q        <= cc_val;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sr1_data = d1_q;
    assign bus.out_sr2_data = d2_q;
    assign bus.out_cc       = cc_q;
    assign bus.sb_error     = err_q;
endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: a reference model checked every cycle plus directed
// scenarios with hand-computed literal expectations.
module tb_operand_issue;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    operand_issue_if bus ();

    operand_issue dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state plus count of outstanding writes.
    logic [15:0] m_rf [8];
    logic [2:0]  m_nzp;
    int          m_pend [8];
    int          m_ccp;
    bit          m_err;
    bit          m_ov;
    logic [15:0] m_d1, m_d2;
    logic [2:0]  m_cc;

    function automatic bit m_ok(input bit use_it, input logic [2:0] r);
        return !use_it || m_pend[r] == 0 ||
               (m_pend[r] == 1 && bus.wb_valid && bus.wb_write && bus.wb_dr == r);
    endfunction

    function automatic bit m_ready();
        bit cc_ok;
        cc_ok = !bus.in_cc_use || m_ccp == 0 || (m_ccp == 1 && bus.wb_valid && bus.wb_load_cc);
        return m_ok(bus.in_sr1_use, bus.in_sr1) && m_ok(bus.in_sr2_use, bus.in_sr2) && cc_ok &&
               !(bus.in_dr_write && m_pend[bus.in_dr] == 3) &&
               !(bus.in_cc_write && m_ccp == 3) &&
               (!m_ov || bus.out_ready);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] r);
        if (bus.wb_valid && bus.wb_write && bus.wb_dr == r) return bus.wb_data;
        return m_rf[r];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 8; r++) begin
                m_rf[r]   <= 16'h0000;
                m_pend[r] <= 0;
            end
            m_nzp <= 3'b010;
            m_ccp <= 0;
            m_err <= 1'b0;
            m_ov  <= 1'b0;
            m_d1  <= 16'h0000;
            m_d2  <= 16'h0000;
            m_cc  <= 3'b000;
        end else begin
            if (bus.wb_valid && bus.wb_write) m_rf[bus.wb_dr] <= bus.wb_data;
            if (bus.wb_valid && bus.wb_load_cc) m_nzp <= bus.wb_cc;
            for (int r = 0; r < 8; r++) begin
                if ((bus.in_valid && m_ready() && bus.in_dr_write && bus.in_dr == 3'(r)) &&
                    !(bus.wb_valid && bus.wb_write && bus.wb_dr == 3'(r)))
                    m_pend[r] <= m_pend[r] + 1;
                else if (!(bus.in_valid && m_ready() && bus.in_dr_write && bus.in_dr == 3'(r)) &&
                         (bus.wb_valid && bus.wb_write && bus.wb_dr == 3'(r))) begin
                    if (m_pend[r] == 0) m_err <= 1'b1;
                    else m_pend[r] <= m_pend[r] - 1;
                end
            end
            if ((bus.in_valid && m_ready() && bus.in_cc_write) && !(bus.wb_valid && bus.wb_load_cc))
                m_ccp <= m_ccp + 1;
            else if (!(bus.in_valid && m_ready() && bus.in_cc_write) && (bus.wb_valid && bus.wb_load_cc)) begin
                if (m_ccp == 0) m_err <= 1'b1;
                else m_ccp <= m_ccp - 1;
            end
            if (bus.in_valid && m_ready()) begin
                m_ov <= 1'b1;
                m_d1 <= m_read(bus.in_sr1);
                m_d2 <= m_read(bus.in_sr2);
                m_cc <= (bus.wb_valid && bus.wb_load_cc) ? bus.wb_cc : m_nzp;
            end else if (bus.out_ready) begin
                m_ov <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("m_in_ready", 32'(bus.in_ready), 32'(m_ready()));
        check("m_out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("m_out_sr1", 32'(bus.out_sr1_data), 32'(m_d1));
        check("m_out_sr2", 32'(bus.out_sr2_data), 32'(m_d2));
        check("m_out_cc", 32'(bus.out_cc), 32'(m_cc));
        check("m_sb_error", 32'(bus.sb_error), 32'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid    = 1'b0;
        bus.in_sr1      = 3'd0;
        bus.in_sr2      = 3'd0;
        bus.in_sr1_use  = 1'b0;
        bus.in_sr2_use  = 1'b0;
        bus.in_dr       = 3'd0;
        bus.in_dr_write = 1'b0;
        bus.in_cc_use   = 1'b0;
        bus.in_cc_write = 1'b0;
        bus.out_ready   = 1'b1;
        bus.wb_valid    = 1'b0;
        bus.wb_write    = 1'b0;
        bus.wb_dr       = 3'd0;
        bus.wb_data     = 16'h0000;
        bus.wb_load_cc  = 1'b0;
        bus.wb_cc       = 3'b000;
    endtask

    task automatic instr(input logic [2:0] sr1, input bit u1, input logic [2:0] sr2, input bit u2,
                         input logic [2:0] dr, input bit dw, input bit ccu, input bit ccw);
        bus.in_valid    = 1'b1;
        bus.in_sr1      = sr1;
        bus.in_sr1_use  = u1;
        bus.in_sr2      = sr2;
        bus.in_sr2_use  = u2;
        bus.in_dr       = dr;
        bus.in_dr_write = dw;
        bus.in_cc_use   = ccu;
        bus.in_cc_write = ccw;
    endtask

    task automatic wb(input logic [2:0] dr, input logic [15:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_write = 1'b1;
        bus.wb_dr    = dr;
        bus.wb_data  = data;
    endtask

    task automatic wb_off();
        bus.wb_valid   = 1'b0;
        bus.wb_write   = 1'b0;
        bus.wb_load_cc = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_sb_error", 32'(bus.sb_error), 32'h0);
        check("rst_out_sr1", 32'(bus.out_sr1_data), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        #1 reset_n = 1'b1;
        tick();

        // Writer of R3, writeback 1234, then a reader of R3.
        instr(0, 0, 0, 0, 3, 1, 0, 0);
        #1 check("r3_writer_ready", 32'(bus.in_ready), 32'h1);
        tick();
        idle();
        wb(3, 16'h1234);
        tick();
        idle();
        instr(3, 1, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        #1;
        check("r3_read", 32'(bus.out_sr1_data), 32'h1234);
        check("r3_valid", 32'(bus.out_valid), 32'h1);
        check("reset_nzp", 32'(bus.out_cc), 32'h2);

        // RAW on R2 resolved by same-cycle writeback bypass.
        instr(0, 0, 0, 0, 2, 1, 0, 0);
        tick();
        idle();
        instr(2, 1, 0, 0, 0, 0, 0, 0);
        #1 check("raw_stall", 32'(bus.in_ready), 32'h0);
        tick();
        #1 check("raw_stall2", 32'(bus.in_ready), 32'h0);
        wb(2, 16'hBEEF);
        #1 check("raw_bypass_ready", 32'(bus.in_ready), 32'h1);
        tick();
        idle();
        #1 check("raw_bypass_data", 32'(bus.out_sr1_data), 32'hBEEF);

        // Three outstanding writers of R5 saturate its counter.
        for (int k = 0; k < 3; k++) begin
            instr(0, 0, 0, 0, 5, 1, 0, 0);
            tick();
        end
        #1 check("waw_full", 32'(bus.in_ready), 32'h0);
        tick();
        wb(5, 16'h5555);
        #1 check("waw_full_wb", 32'(bus.in_ready), 32'h0);
        tick();
        wb_off();
        #1 check("waw_freed", 32'(bus.in_ready), 32'h1);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            wb(5, 16'h0005);
            tick();
        end
        idle();
        tick();

        // Output backpressure, then back-to-back issue once released.
        instr(3, 1, 0, 0, 0, 0, 0, 0);
        tick();
        bus.out_ready = 1'b0;
        instr(2, 1, 0, 0, 0, 0, 0, 0);
        #1;
        check("bp_ready", 32'(bus.in_ready), 32'h0);
        check("bp_data", 32'(bus.out_sr1_data), 32'h1234);
        tick();
        tick();
        #1;
        check("bp_hold_data", 32'(bus.out_sr1_data), 32'h1234);
        check("bp_hold_valid", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        #1 check("bp_release", 32'(bus.in_ready), 32'h1);
        tick();
        instr(5, 1, 0, 0, 0, 0, 0, 0);
        #1;
        check("b2b_data", 32'(bus.out_sr1_data), 32'hBEEF);
        check("b2b_ready", 32'(bus.in_ready), 32'h1);
        tick();
        idle();
        #1;
        check("b2b_data2", 32'(bus.out_sr1_data), 32'h0005);
        check("b2b_valid", 32'(bus.out_valid), 32'h1);

        // NZP hazard: branch waits for the flag-setting writeback.
        instr(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle();
        instr(0, 0, 0, 0, 0, 0, 1, 0);
        #1 check("cc_stall", 32'(bus.in_ready), 32'h0);
        tick();
        #1 check("cc_stall2", 32'(bus.in_ready), 32'h0);
        bus.wb_valid   = 1'b1;
        bus.wb_load_cc = 1'b1;
        bus.wb_cc      = 3'b100;
        #1 check("cc_bypass_ready", 32'(bus.in_ready), 32'h1);
        tick();
        idle();
        #1 check("cc_bypass", 32'(bus.out_cc), 32'h4);

        // Unexpected writeback: sticky error, write still lands.
        check("err_before", 32'(bus.sb_error), 32'h0);
        wb(1, 16'h00AA);
        tick();
        idle();
        #1 check("err_set", 32'(bus.sb_error), 32'h1);
        tick();
        tick();
        #1 check("err_sticky", 32'(bus.sb_error), 32'h1);
        instr(1, 1, 1, 1, 0, 0, 0, 0);
        tick();
        idle();
        #1;
        check("err_write_sr1", 32'(bus.out_sr1_data), 32'h00AA);
        check("same_src_sr2", 32'(bus.out_sr2_data), 32'h00AA);

        // Source equal to own destination reads the pre-increment state.
        instr(4, 1, 0, 0, 4, 1, 0, 0);
        #1 check("self_dep_ready", 32'(bus.in_ready), 32'h1);
        tick();
        idle();
        #1 check("self_dep_data", 32'(bus.out_sr1_data), 32'h0000);

        // Reset asserted in the middle of a stall.
        instr(0, 0, 0, 0, 6, 1, 0, 0);
        tick();
        instr(6, 1, 0, 0, 0, 0, 0, 0);
        #1 check("pre_rst_stall", 32'(bus.in_ready), 32'h0);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_err", 32'(bus.sb_error), 32'h0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'h1);
        check("mid_rst_sr1", 32'(bus.out_sr1_data), 32'h0);
        tick();
        #2 reset_n = 1'b1;
        tick();
        idle();
        #1;
        check("post_rst_valid", 32'(bus.out_valid), 32'h1);
        check("post_rst_data", 32'(bus.out_sr1_data), 32'h0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  decode presents an instruction.
REQ-005 in_ready  output  1  instruction accepted this cycle when in_valid is also high.
REQ-006 in_sr1, in_sr2  input  3 each  source register numbers.
REQ-007 in_sr1_use, in_sr2_use  input  1 each  source is actually read.
REQ-008 in_dr  input  3  destination register; in_dr_write  input  1  instruction writes in_dr.
REQ-009 in_cc_use  input  1  instruction reads NZP (branch); in_cc_write  input  1  instruction sets NZP.
REQ-010 out_valid  output  1; out_ready  input  1  downstream handshake.
REQ-011 out_sr1_data, out_sr2_data  output  16 each; out_cc  output  3  captured operands and NZP.
REQ-012 wb_valid  input  1; wb_write  input  1; wb_dr  input  3; wb_data  input  16  writeback port.
REQ-013 wb_load_cc  input  1; wb_cc  input  3  writeback NZP update (qualified by wb_valid).
REQ-014 sb_error  output  1  sticky scoreboard underflow/overflow flag.

Function
REQ-015 The block SHALL hold an 8 x 16-bit register file, one 3-bit NZP register, a 2-bit pending counter per register and one 2-bit NZP pending counter.
REQ-016 Writeback: when wb_valid && wb_write, regfile[wb_dr] <= wb_data at the clock edge; when wb_valid && wb_load_cc, NZP <= wb_cc.
REQ-017 Bypass: a source read of register r SHALL return wb_data when wb_valid && wb_write && wb_dr == r in the same cycle; otherwise the stored value. NZP reads bypass wb_cc the same way.
REQ-018 A source r is ready when it is unused, when pending[r] == 0, or when pending[r] == 1 and the same-cycle writeback targets r; the NZP source follows the same rule.
REQ-019 Hazard = any used source not ready, OR (in_dr_write && pending[in_dr] == 3), OR (in_cc_write && cc_pending == 3).
REQ-020 in_ready = !hazard && (!out_valid || out_ready), computed combinationally.
REQ-021 Issue = in_valid && in_ready; on issue, the output register SHALL capture the bypassed operands and NZP, and out_valid SHALL be 1 the next cycle (latency 1).
REQ-022 When out_valid && out_ready and there is no issue, out_valid SHALL clear; when out_valid && !out_ready, outputs SHALL hold unchanged.
REQ-023 Counter update per register: +1 on issue with in_dr_write targeting it, -1 on wb_valid && wb_write targeting it; simultaneous +1 and -1 SHALL leave it unchanged. The NZP counter uses in_cc_write and wb_load_cc.
REQ-024 A decrement of a zero counter SHALL leave the counter at 0 and set sb_error. The write itself SHALL still occur.
REQ-025 An instruction whose source equals its own in_dr SHALL read the pre-increment state.
REQ-026 If in_sr1 == in_sr2 and both are used, both outputs SHALL carry the same value.

Reset
REQ-027 While reset_n is low, the following SHALL hold: all registers = 16'h0000, NZP = 3'b010, all counters = 0, out_valid = 0, outputs = 0, sb_error = 0.
REQ-028 Deassertion SHALL be usable on any edge. In-flight instructions are discarded and no writeback is expected afterwards.

Verification
REQ-029 Reset, then wb writes R3 = 16'h1234. The next instruction reads R3 -> out_sr1_data = 16'h1234 one cycle after issue.
REQ-030 Issue instr writing R2. The next instruction reads R2 -> in_ready = 0. When wb R2 = 16'hBEEF arrives, in_ready = 1 in the same cycle and out_sr1_data = 16'hBEEF.
REQ-031 Issue three writers of R5 without writeback. A fourth writer of R5 -> in_ready = 0 until one wb of R5.
REQ-032 Hold out_ready = 0 with out_valid = 1 -> in_ready = 0 and outputs stable. Raise out_ready with in_valid = 1 -> back-to-back issue with no bubble.
REQ-033 Branch with in_cc_use after a CC-setting issue -> stall until wb_load_cc with wb_cc = 3'b100, then out_cc = 3'b100.
REQ-034 wb to R1 with pending[R1] == 0 -> sb_error = 1 and sticky, and R1 is still updated. Assert reset_n mid-stall -> all counters = 0 and out_valid = 0 immediately.
